// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction, waits for its data-SRAM response, aligns and extends load data.
// Latency: 1 cycle for non-memory ops, same cycle as owned data_ok otherwise; a response that WB cannot take yet is buffered.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_to_ms_valid,
    input  logic [31:0] es_pc,
    input  logic [31:0] es_alu_result,
    input  logic [4:0]  es_dest,
    input  logic        es_gr_we,
    input  logic [4:0]  es_ld_op,
    input  logic        es_mem_req,
    input  logic        es_ex,
    input  logic [5:0]  es_ecode,
    input  logic        es_cancel_req,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    input  logic        ms_flush,
    output logic        ms_allowin,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_final_result,
    output logic [4:0]  ms_dest,
    output logic        ms_gr_we,
    output logic        ms_ex,
    output logic [5:0]  ms_ecode,
    output logic        ms_fwd_valid,
    output logic [4:0]  ms_fwd_dest,
    output logic [31:0] ms_fwd_data,
    output logic        ms_ld_block
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [4:0]  dest;
        logic        gr_we;
        logic [4:0]  ld_op;
        logic        mem_req;
        logic        ex;
        logic [5:0]  ecode;
    } ms_payload_t;

    ms_payload_t pl_q, pl_d;
    logic        ms_valid_q, ms_valid_d;
    logic        rbuf_valid_q, rbuf_valid_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [1:0]  discard_cnt_q, discard_cnt_d;

    logic        owned_ok;
    logic        ms_ready_go;
    logic        handoff;
    logic        inc_ms;
    logic        dec;
    logic [2:0]  cnt_sum;
    logic [31:0] ld_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // A response is ours only once every response owed to squashed requests has drained.
    always_comb begin
        owned_ok       = data_sram_data_ok & (discard_cnt_q == 2'd0);
        ms_ready_go    = ~pl_q.mem_req | rbuf_valid_q | owned_ok;
        ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
        ms_to_ws_valid = ms_valid_q & ms_ready_go & ~ms_flush;
        handoff        = ms_to_ws_valid & ws_allowin;
    end

    always_comb begin
        ld_word = rbuf_valid_q ? rbuf_q : data_sram_rdata;
        unique case (pl_q.alu_result[1:0])
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = pl_q.alu_result[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data = ld_word;
        if (pl_q.ld_op[0])      ld_data = {{24{ld_byte[7]}}, ld_byte};
        else if (pl_q.ld_op[1]) ld_data = {24'd0, ld_byte};
        else if (pl_q.ld_op[2]) ld_data = {{16{ld_half[15]}}, ld_half};
        else if (pl_q.ld_op[3]) ld_data = {16'd0, ld_half};
        ms_final_result = (|pl_q.ld_op) ? ld_data : pl_q.alu_result;
    end

    always_comb begin
        ms_valid_d    = ms_valid_q;
        pl_d          = pl_q;
        rbuf_valid_d  = rbuf_valid_q;
        rbuf_d        = rbuf_q;

        if (ms_flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        if (es_to_ms_valid & ms_allowin & ~ms_flush) begin
            pl_d = '{pc: es_pc, alu_result: es_alu_result, dest: es_dest, gr_we: es_gr_we,
                     ld_op: es_ld_op, mem_req: es_mem_req, ex: es_ex, ecode: es_ecode};
        end

        if (ms_flush | handoff) begin
            rbuf_valid_d = 1'b0;
        end else if (ms_valid_q & pl_q.mem_req & ~rbuf_valid_q & owned_ok & ~ws_allowin) begin
            rbuf_valid_d = 1'b1;
            rbuf_d       = data_sram_rdata;
        end

        // A flushed load still owed its response adds one to swallow; so does EX's dropped request.
        inc_ms  = ms_flush & ms_valid_q & pl_q.mem_req & ~rbuf_valid_q & ~owned_ok;
        dec     = data_sram_data_ok & (discard_cnt_q != 2'd0);
        cnt_sum = {1'b0, discard_cnt_q} + {2'b0, inc_ms} + {2'b0, es_cancel_req} - {2'b0, dec};
        discard_cnt_d = (cnt_sum > 3'd2) ? 2'd2 : cnt_sum[1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q    <= 1'b0;
            pl_q          <= '0;
            rbuf_valid_q  <= 1'b0;
            rbuf_q        <= '0;
            discard_cnt_q <= '0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            pl_q          <= pl_d;
            rbuf_valid_q  <= rbuf_valid_d;
            rbuf_q        <= rbuf_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    always_comb begin
        ms_pc        = pl_q.pc;
        ms_dest      = pl_q.dest;
        ms_gr_we     = pl_q.gr_we;
        ms_ex        = pl_q.ex;
        ms_ecode     = pl_q.ecode;
        ms_fwd_valid = ms_valid_q & pl_q.gr_we;
        ms_fwd_dest  = pl_q.dest;
        ms_fwd_data  = ms_final_result;
        ms_ld_block  = ms_valid_q & (|pl_q.ld_op) & ~ms_ready_go;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage LoongArch pipeline, between the execute stage and `wb_stage`. It holds one instruction at a time and waits for the data-SRAM response of a load or store issued in EX. It aligns and sign/zero-extends load data, then hands the result to WB through the valid/allowin handshake. It also discards responses that belong to requests squashed by a WB exception or `ertn` flush, and exposes forwarding and load-use block information to ID.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register index).
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- es_to_ms_valid  in  1  EX presents an instruction
- es_pc / es_alu_result  in  32 / 32  PC; ALU result or memory address
- es_dest / es_gr_we  in  5 / 1  destination register, GPR write enable
- es_ld_op  in  5  one-hot {ld_w, ld_hu, ld_h, ld_bu, ld_b}; 0 means not a load
- es_mem_req  in  1  EX had a data request accepted (addr_ok) for this instruction
- es_ex / es_ecode  in  1 / 6  exception already raised upstream, its code
- es_cancel_req  in  1  on a flush cycle, EX holds an accepted request that EX itself drops
- data_sram_data_ok / data_sram_rdata  in  1 / 32  in-order SRAM-like response
- ws_allowin  in  1  WB can accept
- ms_flush  in  1  WB exception or ertn (`ws_ex_o | ws_ertn`)
- ms_allowin  out  1  MS can accept from EX
- ms_to_ws_valid  out  1  MS presents a finished instruction
- ms_pc / ms_final_result  out  32 / 32  to WB bus
- ms_dest / ms_gr_we  out  5 / 1  to WB bus
- ms_ex / ms_ecode  out  1 / 6  to WB bus
- ms_fwd_valid / ms_fwd_dest / ms_fwd_data  out  1 / 5 / 32  bypass to ID
- ms_ld_block  out  1  ID must stall; a load in MS has no data yet

## Operation
- **Registers:** `ms_valid`, the payload regs, `rbuf` (32 bits), `rbuf_valid`, and `discard_cnt` (2 bits).
- **Ownership rule:** a `data_ok` belongs to the MS instruction only when `discard_cnt == 0`. Otherwise it is swallowed and `discard_cnt` decrements.
- **Ready condition:**
  - `ms_ready_go = ~ms_mem_req | rbuf_valid | (data_sram_data_ok & discard_cnt == 0)`.
  - `ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin)`.
  - `ms_to_ws_valid = ms_valid & ms_ready_go & ~ms_flush`.
- **Valid update:** `ms_flush` forces `ms_valid <= 0` and takes priority. Otherwise, when `ms_allowin`, `ms_valid <= es_to_ms_valid`.
- **Payload capture:** the payload is captured on `es_to_ms_valid & ms_allowin & ~ms_flush`.
- **Response buffering:**
  - An owned `data_ok` arriving while MS cannot leave (`~ws_allowin`) sets `rbuf_valid` and loads `rbuf`.
  - `rbuf_valid` clears when MS hands off (`ms_to_ws_valid & ws_allowin`) or on `ms_flush`.
- **Load data source:** `rbuf` when `rbuf_valid`, else `data_sram_rdata`.
- **Load alignment and extension:** offset is `ms_alu_result[1:0]`.
  - ld_b / ld_bu: byte at offset × 8, sign- or zero-extended to 32.
  - ld_h / ld_hu: halfword at offset[1] × 16, sign- or zero-extended.
  - ld_w: full word.
  - Misalignment is trapped in EX; MS never sees it.
- **Final result:** `ms_final_result` = extended load data if `|ms_ld_op`, else `ms_alu_result`.
- **Exceptions:** `ms_ex` passes through unchanged. EX guarantees `es_mem_req = 0` when `es_ex = 1`.
- **Discard counter:** `discard_cnt_next = discard_cnt + inc_ms + es_cancel_req − dec`, where:
  - `inc_ms = ms_flush & ms_valid & ms_mem_req & ~rbuf_valid & ~(data_ok & discard_cnt == 0)`.
  - `dec = data_ok & (discard_cnt != 0)`.
  - The maximum is 2 (one in MS, one in EX). A result above 2 is a protocol violation and is clamped to 2.
- **Forwarding:**
  - `ms_fwd_valid = ms_valid & ms_gr_we`.
  - `ms_fwd_data = ms_final_result`.
  - `ms_ld_block = ms_valid & |ms_ld_op & ~ms_ready_go`.

## Timing
- **Reset (async, `resetn` low):**
  - `ms_valid`, `rbuf_valid`, `discard_cnt`, and all payload registers go to 0.
  - Outputs go to `ms_allowin = 1`, `ms_to_ws_valid = 0`, `ms_fwd_valid = 0`, `ms_ld_block = 0`, data/pc/dest/ecode = 0.
  - Reset mid-transaction drops everything. Outstanding responses are also reset outside this block.
- **Latency:**
  - Non-memory instruction: 1 cycle in MS.
  - Memory instruction: MS completes combinationally in the cycle `data_ok` arrives (rdata → `ms_final_result` is a same-cycle path), or one cycle after buffering once `ws_allowin` returns.
- **Handshake:** transfer to WB happens on `ms_to_ws_valid & ws_allowin`. The payload is stable while `ms_to_ws_valid & ~ws_allowin`.
- **Flush:**
  - Takes effect at the next edge.
  - `ms_to_ws_valid` is masked in the flush cycle itself.
  - Flush in the same cycle as an owned `data_ok`: the data is consumed and dropped with no counter increment.
  - Flush in the same cycle as a swallowed `data_ok`: `dec` and `inc_ms` both apply.
- **Back-to-back:** a new instruction may enter in the same cycle the previous one leaves.

## Test plan
- **ALU pass-through:** `add`, dest=r5, result 0x1234, `ws_allowin=1` → `ms_to_ws_valid` 1 cycle after entry, `ms_final_result=0x1234`, `ms_fwd_valid=1`.
- **Byte and halfword loads:** `ld_b` at address 0x…3 with rdata 0x80FF_0000 → result 0xFFFF_FF80. `ld_hu` at address 0x…2 with the same rdata → 0x0000_80FF.
- **Late response:** load enters and `data_ok` arrives 3 cycles later → `ms_ld_block=1` for 3 cycles, `ms_allowin=0`, then completion in the `data_ok` cycle.
- **Response buffering:** `data_ok` with rdata 0xDEADBEEF while `ws_allowin=0` for 2 cycles → `rbuf_valid=1`, result held. Hand-off occurs when `ws_allowin=1`, with the same data.
- **Flush discard:** load waiting in MS, `ms_flush` with `es_cancel_req=1` → `discard_cnt=2`. The next two `data_ok` pulses are swallowed. A new load entered afterwards receives the third `data_ok`.
- **Reset mid-wait:** `resetn` low while a load waits with `discard_cnt=1` → all state 0 immediately and `ms_allowin=1`.
